timer_mode_ctrl: RTL and testbench

Mode controller for the Lab 6 stopwatch/timer. It sequences the 4-digit BCD up/down counter datapath: it selects one of four count modes, builds the start or preset value, issues load pulses, and gates counting with the centisecond tick. It stops the counter at its terminal value. It sits between the synchronized board buttons/switches and the counter/display path.

---
 rtl/timer_mode_if.sv | 27 ++
 rtl/timer_mode_ctrl.sv | 81 ++++++++
 tb/tb_timer_mode_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/timer_mode_if.sv
// timer_mode_if: control bus between the stopwatch mode controller and its environment
//   inputs to controller : mode, startStop, clr, setTime, presetSw, tick, atZero, atMax
//   outputs of controller: load, loadVal, countEn, countUp, running, done
interface timer_mode_if;
    logic [1:0]  mode;
    logic        startStop;
    logic        clr;
    logic        setTime;
    logic [7:0]  presetSw;
    logic        tick;
    logic        atZero;
    logic        atMax;
    logic        load;
    logic [15:0] loadVal;
    logic        countEn;
    logic        countUp;
    logic        running;
    logic        done;
    modport master (
        input  mode, startStop, clr, setTime, presetSw, tick, atZero, atMax,
        output load, loadVal, countEn, countUp, running, done
    );
    modport slave (
        output mode, startStop, clr, setTime, presetSw, tick, atZero, atMax,
        input  load, loadVal, countEn, countUp, running, done
    );
endinterface

// File: rtl/timer_mode_ctrl.sv
// timer_mode_ctrl: mode sequencer for the 4-digit BCD stopwatch/timer counter
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : timer_mode_if.master -- buttons, preset switches, tick and counter
//           flags in; load/loadVal/countEn/countUp/running/done out
module timer_mode_ctrl (
    input logic          clk,
    input logic          rst_n,
    timer_mode_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
    state_t      state, state_nxt;
    logic [1:0]  mode_reg, mode_nxt;
    logic [2:0]  prev;
    logic        init_load;
    logic        load_nxt;
    logic [15:0] load_val_nxt;
    logic        ss_e, clr_e, set_e, terminal;
    logic [3:0]  tens, units;
    logic [15:0] preset_val;
    function automatic logic [15:0] start_val(input logic [1:0] m, input logic [15:0] p);
        return m[0] ? p : (m[1] ? 16'h9999 : 16'h0000);
    endfunction
    assign ss_e       = bus.startStop & ~prev[2];
    assign clr_e      = bus.clr & ~prev[1];
    assign set_e      = bus.setTime & ~prev[0];
    assign tens       = bus.presetSw[7:4] > 4'd9 ? 4'd9 : bus.presetSw[7:4];
    assign units      = bus.presetSw[3:0] > 4'd9 ? 4'd9 : bus.presetSw[3:0];
    assign preset_val = {tens, units, 8'h00};
    assign terminal   = bus.countUp ? bus.atMax : bus.atZero;
    // Gated off in the terminal cycle so the counter never wraps past its end value
    assign bus.countEn = (state == RUN) & bus.tick & ~terminal & ~bus.load;
    assign bus.running = (state == RUN);
    assign bus.done    = (state == DONE);
    always_comb begin
        state_nxt    = state;
        mode_nxt     = mode_reg;
        load_nxt     = 1'b0;
        load_val_nxt = bus.loadVal;
        if (init_load) begin
            mode_nxt     = bus.mode;
            load_nxt     = 1'b1;
            load_val_nxt = start_val(bus.mode, preset_val);
        end else if (clr_e) begin
            state_nxt    = IDLE;
            load_nxt     = 1'b1;
            load_val_nxt = start_val(mode_reg, preset_val);
        end else if (set_e && state != RUN) begin
            load_nxt     = 1'b1;
            load_val_nxt = preset_val;
            state_nxt    = (state == DONE) ? IDLE : state;
        end else if (state == RUN && terminal) begin
            state_nxt = DONE;
        end else if (ss_e && state != DONE) begin
            state_nxt = (state == RUN) ? PAUSE : RUN;
        end else if (state == IDLE && bus.mode != mode_reg) begin
            mode_nxt     = bus.mode;
            load_nxt     = 1'b1;
            load_val_nxt = start_val(bus.mode, preset_val);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_reg    <= 2'd0;
            prev        <= 3'b111;
            init_load   <= 1'b1;
            bus.load    <= 1'b0;
            bus.loadVal <= 16'h0000;
            bus.countUp <= 1'b1;
        end else begin
            state       <= state_nxt;
            mode_reg    <= mode_nxt;
            prev        <= {bus.startStop, bus.clr, bus.setTime};
            init_load   <= 1'b0;
            bus.load    <= load_nxt;
            bus.loadVal <= load_val_nxt;
            bus.countUp <= ~mode_nxt[1];
        end
    end
endmodule

// File: tb/tb_timer_mode_ctrl.sv
// tb_timer_mode_ctrl: randomized + directed check of timer_mode_ctrl against a decimal reference model
module tb_timer_mode_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    timer_mode_if bus ();
    timer_mode_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus.master));
    int errs = 0;
    int checks = 0;
    // reference model: states 0 idle, 1 run, 2 pause, 3 done; values kept as decimal integers
    int ms, mm, ev, cnt;
    bit el, eup, minit, pss, pclr, pset;
    assign bus.atZero = (cnt == 0);
    assign bus.atMax  = (cnt == 9999);
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction
    function automatic int preset_dec();
        int t, u;
        t = bus.presetSw[7:4] > 9 ? 9 : int'(bus.presetSw[7:4]);
        u = bus.presetSw[3:0] > 9 ? 9 : int'(bus.presetSw[3:0]);
        return t * 1000 + u * 100;
    endfunction
    function automatic int start_dec(input int m);
        return m == 0 ? 0 : m == 2 ? 9999 : preset_dec();
    endfunction
    function automatic bit exp_en();
        bit at_end;
        at_end = eup ? (cnt == 9999) : (cnt == 0);
        return ms == 1 && bus.tick && !at_end && !el;
    endfunction
    task automatic model_step();
        bit ss, ce, se, at_end;
        ss = bus.startStop && !pss;
        ce = bus.clr && !pclr;
        se = bus.setTime && !pset;
        at_end = eup ? (cnt == 9999) : (cnt == 0);
        el = 0;
        if (minit) begin
            mm = int'(bus.mode); el = 1; ev = start_dec(mm); minit = 0;
        end else if (ce) begin
            ms = 0; el = 1; ev = start_dec(mm);
        end else if (se && ms != 1) begin
            el = 1; ev = preset_dec();
            if (ms == 3) ms = 0;
        end else if (ms == 1 && at_end) begin
            ms = 3;
        end else if (ss && ms != 3) begin
            ms = (ms == 1) ? 2 : 1;
        end else if (ms == 0 && int'(bus.mode) != mm) begin
            mm = int'(bus.mode); el = 1; ev = start_dec(mm);
        end
        eup = (mm < 2);
        pss = bus.startStop; pclr = bus.clr; pset = bus.setTime;
    endtask
    task automatic check_reset_outputs(input string tag);
        check({tag, "_load"}, bus.load, 1'b0);
        check({tag, "_loadVal"}, bus.loadVal, 16'h0000);
        check({tag, "_countEn"}, bus.countEn, 1'b0);
        check({tag, "_countUp"}, bus.countUp, 1'b1);
        check({tag, "_running"}, bus.running, 1'b0);
        check({tag, "_done"}, bus.done, 1'b0);
    endtask
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ms = 0; mm = 0; ev = 0; el = 0; eup = 1; minit = 1;
        pss = 1; pclr = 1; pset = 1;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    // inputs are set before calling; checks combinational countEn, then registered outputs after the edge
    task automatic cycle();
        bit en, ol, ou;
        int ov;
        #1;
        en = exp_en();
        check("countEn", bus.countEn, en);
        ol = el; ov = ev; ou = eup;
        model_step();
        @(posedge clk);
        #1;
        if (ol) cnt = ov;
        else if (en) cnt = ou ? cnt + 1 : cnt - 1;
        check("load", bus.load, el);
        check("loadVal", bus.loadVal, to_bcd(ev));
        check("countUp", bus.countUp, eup);
        check("running", bus.running, ms == 1);
        check("done", bus.done, ms == 3);
    endtask
    task automatic press_ss();
        bus.startStop = 1; cycle(); bus.startStop = 0; cycle();
    endtask
    task automatic press_clr();
        bus.clr = 1; cycle(); bus.clr = 0; cycle();
    endtask
    task automatic press_set();
        bus.setTime = 1; cycle(); bus.setTime = 0; cycle();
    endtask
    initial begin
        cnt = 0;
        bus.mode = 2; bus.startStop = 0; bus.clr = 0; bus.setTime = 0;
        bus.presetSw = 8'h00; bus.tick = 1;
        @(posedge clk); #1;
        do_reset("rst");
        @(posedge clk); #1;
        check("init_load", bus.load, 1'b1);
        check("init_val", bus.loadVal, 16'h9999);
        check("init_up", bus.countUp, 1'b0);
        cnt = 9999;
        el = 1; ev = 9999; minit = 0; mm = 2; eup = 0;
        cycle();
        cycle();
        bus.mode = 1; bus.presetSw = 8'h3F;
        cycle();
        check("preset_clamp", bus.loadVal, 16'h3900);
        bus.startStop = 1;
        for (int i = 0; i < 5; i++) begin
            bus.tick = i[0];
            cycle();
        end
        bus.startStop = 0;
        for (int i = 0; i < 6; i++) begin
            bus.tick = 1'($urandom_range(0, 1));
            cycle();
        end
        check("hold_once_running", bus.running, 1'b1);
        bus.tick = 0;
        press_clr();
        bus.mode = 3; bus.presetSw = 8'h01;
        cycle();
        check("preset_0100", bus.loadVal, 16'h0100);
        press_ss();
        bus.tick = 1;
        for (int i = 0; i < 300 && ms != 3; i++) cycle();
        check("reached_done", bus.done, 1'b1);
        check("done_at_zero", cnt, 0);
        press_ss();
        check("done_ignores_ss", bus.done, 1'b1);
        press_set();
        check("done_set_idle", bus.done, 1'b0);
        bus.mode = 2;
        cycle();
        press_ss();
        for (int i = 0; i < 4; i++) cycle();
        press_ss();
        for (int i = 0; i < 3; i++) cycle();
        check("pause_running", bus.running, 1'b0);
        bus.mode = 0;
        cycle(); cycle();
        check("pause_no_load", bus.load, 1'b0);
        bus.clr = 1; cycle();
        check("clr_frozen_val", bus.loadVal, 16'h9999);
        bus.clr = 0; cycle();
        check("clr_then_mode", bus.loadVal, 16'h0000);
        press_ss();
        cycle();
        bus.clr = 1; bus.startStop = 1; cycle();
        check("clr_ss_idle", bus.running, 1'b0);
        bus.clr = 0; bus.startStop = 0; cycle();
        press_ss();
        cycle();
        @(negedge clk);
        do_reset("midrun");
        cycle();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.startStop = ~bus.startStop;
            if ($urandom_range(0, 23) == 0) bus.clr = ~bus.clr;
            if ($urandom_range(0, 23) == 0) bus.setTime = ~bus.setTime;
            if ($urandom_range(0, 40) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 30) == 0)
                bus.presetSw = {($urandom_range(0, 9) == 0) ? 4'hF : 4'd0, 4'($urandom_range(0, 15))};
            bus.tick = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 600) == 0) do_reset("rnd_rst");
            cycle();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
